// File: rtl/riscv_main_fsm_if.sv
// Control bundle between the multicycle RV32I main controller and its datapath.
// The master side is the controller; the slave side is the datapath that consumes enables and selects.
interface riscv_main_fsm_if;
    logic [6:0] op;
    logic       branch_taken;
    logic       ir_write;
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] result_src;
    logic [2:0] imm_src;

    modport master (
        input  op, branch_taken,
        output ir_write, pc_write, adr_src, mem_write, reg_write,
               alu_src_a, alu_src_b, alu_op, result_src, imm_src
    );

    modport slave (
        output op, branch_taken,
        input  ir_write, pc_write, adr_src, mem_write, reg_write,
               alu_src_a, alu_src_b, alu_op, result_src, imm_src
    );
endinterface

// File: rtl/riscv_main_fsm.sv
// Multicycle RV32I main controller: Moore FSM driving datapath enables/selects plus a retired-instruction counter.
// Optional macro ILLEGAL_TRAP_EN: illegal opcodes enter a sticky TRAP state (halted=1) instead of acting as a NOP.
module riscv_main_fsm #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    riscv_main_fsm_if.master     ctl,
    output logic [CNT_WIDTH-1:0] instret,
    output logic                 halted
);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_JALRWB,
        S_LUI, S_AUIPC
`ifdef ILLEGAL_TRAP_EN
        , S_TRAP
`endif
    } state_t;

    state_t state, state_nxt;

    logic       ir_write_c, pc_update_c, branch_c, adr_src_c, mem_write_c, reg_write_c;
    logic [1:0] alu_src_a_c, alu_src_b_c, alu_op_c, result_src_c;
    logic       retire;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_FETCH;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        ir_write_c   = 1'b0;
        pc_update_c  = 1'b0;
        branch_c     = 1'b0;
        adr_src_c    = 1'b0;
        mem_write_c  = 1'b0;
        reg_write_c  = 1'b0;
        alu_src_a_c  = 2'b00;
        alu_src_b_c  = 2'b00;
        alu_op_c     = 2'b00;
        result_src_c = 2'b00;
        case (state)
            S_FETCH: begin
                ir_write_c   = 1'b1;
                pc_update_c  = 1'b1;
                alu_src_b_c  = 2'b10;
                result_src_c = 2'b10;
                state_nxt    = S_DECODE;
            end
            S_DECODE: begin
                // ALUOut captures OldPC + imm so BRANCH/JAL find their target ready.
                alu_src_a_c = 2'b01;
                alu_src_b_c = 2'b01;
                case (ctl.op)
                    7'b0000011, 7'b0100011: state_nxt = S_MEMADR;
                    7'b0110011:             state_nxt = S_EXECR;
                    7'b0010011:             state_nxt = S_EXECI;
                    7'b1100011:             state_nxt = S_BRANCH;
                    7'b1101111:             state_nxt = S_JAL;
                    7'b1100111:             state_nxt = S_JALR;
                    7'b0110111:             state_nxt = S_LUI;
                    7'b0010111:             state_nxt = S_AUIPC;
`ifdef ILLEGAL_TRAP_EN
                    default:                state_nxt = S_TRAP;
`else
                    default:                state_nxt = S_FETCH;
`endif
                endcase
            end
            S_MEMADR: begin
                alu_src_a_c = 2'b10;
                alu_src_b_c = 2'b01;
                state_nxt   = ctl.op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                adr_src_c = 1'b1;
                state_nxt = S_MEMWB;
            end
            S_MEMWB: begin
                result_src_c = 2'b01;
                reg_write_c  = 1'b1;
                state_nxt    = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_src_c   = 1'b1;
                mem_write_c = 1'b1;
                state_nxt   = S_FETCH;
            end
            S_EXECR: begin
                alu_src_a_c = 2'b10;
                alu_op_c    = 2'b10;
                state_nxt   = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_a_c = 2'b10;
                alu_src_b_c = 2'b01;
                alu_op_c    = 2'b10;
                state_nxt   = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write_c = 1'b1;
                state_nxt   = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a_c = 2'b10;
                alu_op_c    = 2'b11;
                branch_c    = 1'b1;
                state_nxt   = S_FETCH;
            end
            S_JAL: begin
                alu_src_a_c = 2'b01;
                alu_src_b_c = 2'b10;
                pc_update_c = 1'b1;
                state_nxt   = S_ALUWB;
            end
            S_JALR: begin
                alu_src_a_c  = 2'b10;
                alu_src_b_c  = 2'b01;
                result_src_c = 2'b10;
                pc_update_c  = 1'b1;
                state_nxt    = S_JALRWB;
            end
            S_JALRWB: begin
                // Link value OldPC + 4 is computed directly, since ALUOut holds the jump target.
                alu_src_a_c  = 2'b01;
                alu_src_b_c  = 2'b10;
                result_src_c = 2'b10;
                reg_write_c  = 1'b1;
                state_nxt    = S_FETCH;
            end
            S_LUI: begin
                alu_src_a_c = 2'b11;
                alu_src_b_c = 2'b01;
                state_nxt   = S_ALUWB;
            end
            S_AUIPC: begin
                alu_src_a_c = 2'b01;
                alu_src_b_c = 2'b01;
                state_nxt   = S_ALUWB;
            end
            default: state_nxt = state;
        endcase
    end

    // Writes are suppressed combinationally while reset is held, so a mid-instruction reset leaves no partial update.
    assign ctl.ir_write   = ir_write_c  & ~reset;
    assign ctl.pc_write   = (pc_update_c | (branch_c & ctl.branch_taken)) & ~reset;
    assign ctl.mem_write  = mem_write_c & ~reset;
    assign ctl.reg_write  = reg_write_c & ~reset;
    assign ctl.adr_src    = adr_src_c;
    assign ctl.alu_src_a  = alu_src_a_c;
    assign ctl.alu_src_b  = alu_src_b_c;
    assign ctl.alu_op     = alu_op_c;
    assign ctl.result_src = result_src_c;

    always_comb begin
        case (ctl.op)
            7'b0100011:             ctl.imm_src = 3'b001;
            7'b1100011:             ctl.imm_src = 3'b010;
            7'b1101111:             ctl.imm_src = 3'b011;
            7'b0110111, 7'b0010111: ctl.imm_src = 3'b100;
            default:                ctl.imm_src = 3'b000;
        endcase
    end

    assign retire = (state == S_MEMWB) || (state == S_MEMWRITE) || (state == S_ALUWB) ||
                    (state == S_BRANCH) || (state == S_JALRWB);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)       instret <= '0;
        else if (retire) instret <= instret + CNT_WIDTH'(1);
    end

`ifdef ILLEGAL_TRAP_EN
    assign halted = (state == S_TRAP);
`else
    assign halted = 1'b0;
`endif

endmodule

// File: doc/riscv_main_fsm.md
Name: riscv_main_fsm

Overview:
Multicycle RV32I main controller. It sequences fetch, decode, execute, memory and writeback, and drives every datapath enable and mux select. It is the producer side of the ALU control interface: it generates the 2-bit alu_op (00 add, 01 sub, 10 funct-decoded, 11 branch compare) that the ALU decoder consumes. It also keeps a retired-instruction counter.

Parameters:
CNT_WIDTH, 32, width of the retired-instruction counter instret.

Ports:
clk  input  1  system clock; all state updates on the rising edge
reset  input  1  asynchronous, active-high reset
op  input  7  opcode field of the instruction register
branch_taken  input  1  branch condition result from the flag/funct3 compare logic; sampled only in BRANCH
ir_write  output  1  instruction register load enable
pc_write  output  1  PC load enable; equals pc_update OR (branch AND branch_taken)
adr_src  output  1  memory address select: 0 = PC, 1 = ALUOut
mem_write  output  1  data memory write enable
reg_write  output  1  register file write enable
alu_src_a  output  2  00 PC, 01 OldPC, 10 rs1 data, 11 zero
alu_src_b  output  2  00 rs2 data, 01 immediate, 10 constant 4
alu_op  output  2  ALU decoder mode
result_src  output  2  00 ALUOut, 01 memory data, 10 ALU result (direct)
imm_src  output  3  combinational from op: I 000, S 001, B 010, J 011, U 100; 000 for R-type and illegal
instret  output  CNT_WIDTH  count of retired instructions
halted  output  1  trap indicator; constant 0 when the optional feature is compiled out

Behaviour:
- Moore FSM with a registered state. All outputs except pc_write and imm_src decode from state only.
- Reset (asynchronous): state goes to FETCH, instret to 0, halted to 0. While reset is high, ir_write, pc_write, mem_write and reg_write are forced to 0; selects take their FETCH values. Reset asserted mid-instruction abandons it with no partial writes after assertion.
- Unlisted outputs are 0 in each state:
  - FETCH: ir_write, pc_update, adr_src 0, A 00, B 10, alu_op 00, result_src 10 -> DECODE
  - DECODE: A 01, B 01, alu_op 00 (branch/JAL target into ALUOut). Next state by op:
    - 0000011 or 0100011 -> MEMADR
    - 0110011 -> EXECR
    - 0010011 -> EXECI
    - 1100011 -> BRANCH
    - 1101111 -> JAL
    - 1100111 -> JALR
    - 0110111 -> LUI
    - 0010111 -> AUIPC
    - any other op: illegal
  - MEMADR: A 10, B 01, alu_op 00 -> MEMREAD if op[5]=0, else MEMWRITE
  - MEMREAD: adr_src 1, result_src 00 -> MEMWB
  - MEMWB: result_src 01, reg_write -> FETCH
  - MEMWRITE: adr_src 1, result_src 00, mem_write -> FETCH
  - EXECR: A 10, B 00, alu_op 10 -> ALUWB
  - EXECI: A 10, B 01, alu_op 10 -> ALUWB
  - ALUWB: result_src 00, reg_write -> FETCH
  - BRANCH: A 10, B 00, alu_op 11, result_src 00, branch=1 -> FETCH
  - JAL: A 01, B 10, alu_op 00, result_src 00, pc_update -> ALUWB
  - JALR: A 10, B 01, alu_op 00, result_src 10, pc_update -> JALRWB
  - JALRWB: A 01, B 10, alu_op 00, result_src 10, reg_write -> FETCH
  - LUI: A 11, B 01, alu_op 00 -> ALUWB
  - AUIPC: A 01, B 01, alu_op 00 -> ALUWB
- Latency in cycles, counted FETCH to next FETCH:
  - lw 5
  - sw, R-type, I-type, jal, jalr, lui, auipc 4
  - branch 3 (taken or not)
- pc_write is combinational. In BRANCH it follows branch_taken within the same cycle. branch_taken is ignored in all other states.
- instret increments by 1 on each clock edge where state is a terminal state (MEMWB, MEMWRITE, ALUWB, BRANCH, JALRWB). It wraps from 2^CNT_WIDTH-1 to 0. Illegal opcodes never increment it.
- Illegal opcode, feature off: DECODE -> FETCH with no writes, i.e. treated as a 2-cycle NOP.

Optional Feature:
ILLEGAL_TRAP_EN
- Defined: an illegal opcode in DECODE moves to TRAP. TRAP is sticky and exits only on reset. In TRAP, halted=1, all enables 0, selects 0, and instret frozen.
- Undefined: the TRAP state and its logic are absent, halted is tied to 0, and illegal opcodes behave as a NOP.

Test Plan:
- Reset asserted for 2 cycles, then released: during reset all enables 0 and instret=0. First cycle after release is FETCH with ir_write=1, pc_write=1, alu_src_b=10.
- op=0000011 (lw): states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, FETCH. reg_write=1 only in MEMWB with result_src=01. instret goes 0 to 1.
- op=1100011 with branch_taken=0, then repeated with branch_taken=1: pc_write=0 then 1 in BRANCH, alu_op=11 in both. Each takes 3 cycles and instret rises by 2 in total.
- op=1100111 (jalr): in JALR, pc_write=1 with A=10, B=01. In JALRWB, reg_write=1 with A=01, B=10. Total 4 cycles.
- CNT_WIDTH=4, run 16 R-type instructions (op=0110011): instret wraps 15 to 0. alu_op=10 in EXECR.
- op=1111111: feature off gives DECODE then FETCH with no writes and instret unchanged. With ILLEGAL_TRAP_EN, halted=1 is held for 10 or more cycles until reset, which clears halted to 0.
